icb_2m1s_sram_arb: RTL and testbench



---
 rtl/icb_arb_pkg.sv | 20 ++
 rtl/icb_arb_chk.sv | 20 ++
 rtl/icb_arb_id_fifo.sv | 84 ++++++++
 rtl/icb_2m1s_sram_arb.sv | 167 ++++++++++++++++
 tb/tb_icb_2m1s_sram_arb.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icb_arb_pkg.sv
// Shared definitions for the two-master ICB arbiter: master id encodings and
// a constant-evaluable log2 helper used to size FIFO pointers and counters.
package icb_arb_pkg;

    localparam int ID_W = 1;

    localparam logic [ID_W-1:0] ID_M0 = 1'b0;
    localparam logic [ID_W-1:0] ID_M1 = 1'b1;

    // Ceiling log2; clog2(1) = 0, callers clamp pointer widths to >= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            result = ((32'sd1 << i) < value) ? (i + 1) : result;
        end
        return result;
    endfunction

endpackage

// File: rtl/icb_arb_chk.sv
// Protocol checker for the arbiter: a slave response with nothing outstanding
// is illegal, and a full id FIFO must never present a command downstream.
module icb_arb_chk (
    input logic clk,
    input logic rst,
    input logic i_rsp_valid,
    input logic i_fifo_empty,
    input logic i_cmd_valid,
    input logic i_fifo_full
);

    a_rsp_needs_outstanding: assert property (
        @(posedge clk) disable iff (rst) !(i_rsp_valid && i_fifo_empty)
    );

    a_no_cmd_when_full: assert property (
        @(posedge clk) disable iff (rst) !(i_cmd_valid && i_fifo_full)
    );

endmodule

// File: rtl/icb_arb_id_fifo.sv
// In-order FIFO of master ids, one entry per accepted command. The head entry
// names the master that owns the next slave response.
module icb_arb_id_fifo
    import icb_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [ID_W-1:0]  i_push_id,
    input  logic             i_pop,
    output logic [ID_W-1:0]  o_head_id,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [PTR_W-1:0] PTR_ZERO = '0;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ID_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_en;
    logic             w_pop_en;

    // Pointer advance with explicit wrap so any depth stays in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? PTR_ZERO : (ptr + PTR_ONE);
    endfunction

    // Overflow/underflow are refused here as a last line of defence.
    assign w_push_en = i_push & ~o_full;
    assign w_pop_en  = i_pop & ~o_empty;

    // Storage write and write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= ID_M0;
            end
            r_wptr <= PTR_ZERO;
        end else if (w_push_en) begin
            r_mem[r_wptr] <= i_push_id;
            r_wptr        <= ptr_inc(r_wptr);
        end
    end

    // Read pointer advances on every accepted pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr <= PTR_ZERO;
        end else if (w_pop_en) begin
            r_rptr <= ptr_inc(r_rptr);
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= CNT_ZERO;
        end else begin
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_id = r_mem[r_rptr];
    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == CNT_ZERO);
    assign o_count   = r_count;

endmodule

// File: rtl/icb_2m1s_sram_arb.sv
// Two-master to one-slave ICB arbiter in front of the SRAM controller.
// Round-robin grant per single-beat command; responses are routed back in
// command order using an id FIFO. The command path adds no latency.
module icb_2m1s_sram_arb
    import icb_arb_pkg::*;
#(
    parameter int DW         = 32,
    parameter int MW         = 4,
    parameter int AW         = 19,
    parameter int USR_W      = 1,
    parameter int OUTS_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             m0_icb_cmd_valid,
    output logic             m0_icb_cmd_ready,
    input  logic             m0_icb_cmd_read,
    input  logic [AW-1:0]    m0_icb_cmd_addr,
    input  logic [DW-1:0]    m0_icb_cmd_wdata,
    input  logic [MW-1:0]    m0_icb_cmd_wmask,
    input  logic [USR_W-1:0] m0_icb_cmd_usr,
    output logic             m0_icb_rsp_valid,
    input  logic             m0_icb_rsp_ready,
    output logic [DW-1:0]    m0_icb_rsp_rdata,
    output logic [USR_W-1:0] m0_icb_rsp_usr,

    input  logic             m1_icb_cmd_valid,
    output logic             m1_icb_cmd_ready,
    input  logic             m1_icb_cmd_read,
    input  logic [AW-1:0]    m1_icb_cmd_addr,
    input  logic [DW-1:0]    m1_icb_cmd_wdata,
    input  logic [MW-1:0]    m1_icb_cmd_wmask,
    input  logic [USR_W-1:0] m1_icb_cmd_usr,
    output logic             m1_icb_rsp_valid,
    input  logic             m1_icb_rsp_ready,
    output logic [DW-1:0]    m1_icb_rsp_rdata,
    output logic [USR_W-1:0] m1_icb_rsp_usr,

    output logic             o_icb_cmd_valid,
    input  logic             o_icb_cmd_ready,
    output logic             o_icb_cmd_read,
    output logic [AW-1:0]    o_icb_cmd_addr,
    output logic [DW-1:0]    o_icb_cmd_wdata,
    output logic [MW-1:0]    o_icb_cmd_wmask,
    output logic [USR_W-1:0] o_icb_cmd_usr,
    input  logic             o_icb_rsp_valid,
    output logic             o_icb_rsp_ready,
    input  logic [DW-1:0]    o_icb_rsp_rdata,
    input  logic [USR_W-1:0] o_icb_rsp_usr,

    output logic             arb_active
);

    localparam int CNT_W = clog2(OUTS_DEPTH + 1);

    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  w_grant_id;
    logic             w_any_req;
    logic             w_both_req;
    logic             w_cmd_hsk;
    logic             w_rsp_hsk;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [ID_W-1:0]  w_head_id;
    logic [CNT_W-1:0] w_fifo_count;

    assign w_any_req  = m0_icb_cmd_valid | m1_icb_cmd_valid;
    assign w_both_req = m0_icb_cmd_valid & m1_icb_cmd_valid;

    // Grant selection: a lone requester wins, contention goes to r_rr_ptr.
    always_comb begin
        w_grant_id = ID_M0;
        if (w_both_req) begin
            w_grant_id = r_rr_ptr;
        end else if (m1_icb_cmd_valid) begin
            w_grant_id = ID_M1;
        end else begin
            w_grant_id = ID_M0;
        end
    end

    // A full FIFO blocks the command path based on registered occupancy only,
    // so slave rsp_ready never reaches master cmd_ready combinationally.
    assign o_icb_cmd_valid = w_any_req & ~w_fifo_full;
    assign w_cmd_hsk       = o_icb_cmd_valid & o_icb_cmd_ready;

    // Command payload mux and per-master ready.
    always_comb begin
        m0_icb_cmd_ready = 1'b0;
        m1_icb_cmd_ready = 1'b0;
        if (w_grant_id == ID_M1) begin
            o_icb_cmd_read  = m1_icb_cmd_read;
            o_icb_cmd_addr  = m1_icb_cmd_addr;
            o_icb_cmd_wdata = m1_icb_cmd_wdata;
            o_icb_cmd_wmask = m1_icb_cmd_wmask;
            o_icb_cmd_usr   = m1_icb_cmd_usr;
            m1_icb_cmd_ready = o_icb_cmd_ready & o_icb_cmd_valid;
        end else begin
            o_icb_cmd_read  = m0_icb_cmd_read;
            o_icb_cmd_addr  = m0_icb_cmd_addr;
            o_icb_cmd_wdata = m0_icb_cmd_wdata;
            o_icb_cmd_wmask = m0_icb_cmd_wmask;
            o_icb_cmd_usr   = m0_icb_cmd_usr;
            m0_icb_cmd_ready = o_icb_cmd_ready & o_icb_cmd_valid;
        end
    end

    // Round-robin pointer rotates only on an accepted command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= ID_M0;
        end else if (w_cmd_hsk) begin
            r_rr_ptr <= ~w_grant_id;
        end
    end

    // Response steering: only the FIFO-head master sees valid. A response
    // with nothing outstanding is swallowed so the slave cannot lock up.
    always_comb begin
        m0_icb_rsp_valid = 1'b0;
        m1_icb_rsp_valid = 1'b0;
        o_icb_rsp_ready  = 1'b0;
        if (w_fifo_empty) begin
            o_icb_rsp_ready = o_icb_rsp_valid;
        end else if (w_head_id == ID_M1) begin
            m1_icb_rsp_valid = o_icb_rsp_valid;
            o_icb_rsp_ready  = m1_icb_rsp_ready;
        end else begin
            m0_icb_rsp_valid = o_icb_rsp_valid;
            o_icb_rsp_ready  = m0_icb_rsp_ready;
        end
    end

    assign w_rsp_hsk = o_icb_rsp_valid & o_icb_rsp_ready & ~w_fifo_empty;

    assign m0_icb_rsp_rdata = o_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = o_icb_rsp_rdata;
    assign m0_icb_rsp_usr   = o_icb_rsp_usr;
    assign m1_icb_rsp_usr   = o_icb_rsp_usr;

    assign arb_active = w_any_req | o_icb_rsp_valid | (w_fifo_count != '0);

    icb_arb_id_fifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_cmd_hsk),
        .i_push_id (w_grant_id),
        .i_pop     (w_rsp_hsk),
        .o_head_id (w_head_id),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    icb_arb_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .i_rsp_valid  (o_icb_rsp_valid),
        .i_fifo_empty (w_fifo_empty),
        .i_cmd_valid  (o_icb_cmd_valid),
        .i_fifo_full  (w_fifo_full)
    );

endmodule

// File: tb/tb_icb_2m1s_sram_arb.sv
// Self-checking bench for icb_2m1s_sram_arb (OUTS_DEPTH = 2).
// Table of hand-derived vectors, then scoreboard-driven sequences.
module tb_icb_2m1s_sram_arb;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
    logic [18:0] m0_icb_cmd_addr;
    logic [31:0] m0_icb_cmd_wdata;
    logic [3:0]  m0_icb_cmd_wmask;
    logic        m0_icb_cmd_usr;
    logic        m0_icb_rsp_valid, m0_icb_rsp_ready;
    logic [31:0] m0_icb_rsp_rdata;
    logic        m0_icb_rsp_usr;
    logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
    logic [18:0] m1_icb_cmd_addr;
    logic [31:0] m1_icb_cmd_wdata;
    logic [3:0]  m1_icb_cmd_wmask;
    logic        m1_icb_cmd_usr;
    logic        m1_icb_rsp_valid, m1_icb_rsp_ready;
    logic [31:0] m1_icb_rsp_rdata;
    logic        m1_icb_rsp_usr;
    logic        o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read;
    logic [18:0] o_icb_cmd_addr;
    logic [31:0] o_icb_cmd_wdata;
    logic [3:0]  o_icb_cmd_wmask;
    logic        o_icb_cmd_usr;
    logic        o_icb_rsp_valid, o_icb_rsp_ready;
    logic [31:0] o_icb_rsp_rdata;
    logic        o_icb_rsp_usr;
    logic        arb_active;

    always #5 clk = ~clk;

    icb_2m1s_sram_arb #(
        .DW(32), .MW(4), .AW(19), .USR_W(1), .OUTS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
        .m0_icb_cmd_read(m0_icb_cmd_read), .m0_icb_cmd_addr(m0_icb_cmd_addr),
        .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
        .m0_icb_cmd_usr(m0_icb_cmd_usr), .m0_icb_rsp_valid(m0_icb_rsp_valid),
        .m0_icb_rsp_ready(m0_icb_rsp_ready), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
        .m0_icb_rsp_usr(m0_icb_rsp_usr),
        .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
        .m1_icb_cmd_read(m1_icb_cmd_read), .m1_icb_cmd_addr(m1_icb_cmd_addr),
        .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
        .m1_icb_cmd_usr(m1_icb_cmd_usr), .m1_icb_rsp_valid(m1_icb_rsp_valid),
        .m1_icb_rsp_ready(m1_icb_rsp_ready), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
        .m1_icb_rsp_usr(m1_icb_rsp_usr),
        .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
        .o_icb_cmd_read(o_icb_cmd_read), .o_icb_cmd_addr(o_icb_cmd_addr),
        .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask),
        .o_icb_cmd_usr(o_icb_cmd_usr), .o_icb_rsp_valid(o_icb_rsp_valid),
        .o_icb_rsp_ready(o_icb_rsp_ready), .o_icb_rsp_rdata(o_icb_rsp_rdata),
        .o_icb_rsp_usr(o_icb_rsp_usr),
        .arb_active(arb_active)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        m0v, m1v;
        logic [18:0] m0a, m1a;
        logic        scr, rv;
        logic [31:0] rdata;
        logic        m0rr, m1rr;
        logic        e_ov, e_m0r, e_m1r;
        logic [18:0] e_addr;
        logic        e_rd, e_m0rv, e_m1rv, e_orr, e_act;
    } vec_t;

    vec_t tbl [12];

    // ---------------- scoreboard model ----------------
    typedef struct packed {
        logic        id;
        logic [31:0] rdata;
    } sb_t;

    sb_t  sb[$];
    logic mdl_rr;
    logic grant_log[$];
    logic rsp_log[$];

    task automatic idle_inputs();
        m0_icb_cmd_valid = 1'b0; m1_icb_cmd_valid = 1'b0;
        m0_icb_cmd_read  = 1'b1; m1_icb_cmd_read  = 1'b0;
        m0_icb_cmd_addr  = 19'h0; m1_icb_cmd_addr = 19'h0;
        m0_icb_cmd_wdata = 32'h0; m1_icb_cmd_wdata = 32'h0;
        m0_icb_cmd_wmask = 4'h0; m1_icb_cmd_wmask = 4'h0;
        m0_icb_cmd_usr   = 1'b0; m1_icb_cmd_usr   = 1'b1;
        m0_icb_rsp_ready = 1'b0; m1_icb_rsp_ready = 1'b0;
        o_icb_cmd_ready  = 1'b0; o_icb_rsp_valid  = 1'b0;
        o_icb_rsp_rdata  = 32'h0; o_icb_rsp_usr   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        mdl_rr = 1'b0;
        sb.delete(); grant_log.delete(); rsp_log.delete();
    endtask

    // One clock of traffic, checked against the scoreboard/model.
    // Entered and left at posedge+1.
    task automatic sb_cycle(input logic v0, input logic v1, input logic rr0,
                            input logic rr1, input logic rv);
        logic full, gid, eov, rv_eff, head, eorr;
        sb_t  popped;
        rv_eff = rv && (sb.size() != 0);
        m0_icb_cmd_valid = v0; m1_icb_cmd_valid = v1;
        m0_icb_rsp_ready = rr0; m1_icb_rsp_ready = rr1;
        o_icb_cmd_ready  = 1'b1;
        o_icb_rsp_valid  = rv_eff;
        o_icb_rsp_rdata  = rv_eff ? sb[0].rdata : 32'h0;
        o_icb_rsp_usr    = rv_eff;
        #2;
        full = (sb.size() == DEPTH);
        gid  = (v0 && v1) ? mdl_rr : v1;
        eov  = (v0 || v1) && !full;
        chk("sb_cmd_valid", o_icb_cmd_valid, eov);
        chk("sb_m0_cmd_ready", m0_icb_cmd_ready, eov && !gid);
        chk("sb_m1_cmd_ready", m1_icb_cmd_ready, eov && gid);
        if (eov) begin
            chk("sb_cmd_addr",  o_icb_cmd_addr,  gid ? m1_icb_cmd_addr  : m0_icb_cmd_addr);
            chk("sb_cmd_read",  o_icb_cmd_read,  gid ? m1_icb_cmd_read  : m0_icb_cmd_read);
            chk("sb_cmd_wdata", o_icb_cmd_wdata, gid ? m1_icb_cmd_wdata : m0_icb_cmd_wdata);
            chk("sb_cmd_wmask", o_icb_cmd_wmask, gid ? m1_icb_cmd_wmask : m0_icb_cmd_wmask);
            chk("sb_cmd_usr",   o_icb_cmd_usr,   gid ? m1_icb_cmd_usr   : m0_icb_cmd_usr);
        end
        eorr = 1'b0;
        if (rv_eff) begin
            head = sb[0].id;
            eorr = head ? rr1 : rr0;
            chk("sb_m0_rsp_valid", m0_icb_rsp_valid, !head);
            chk("sb_m1_rsp_valid", m1_icb_rsp_valid, head);
            chk("sb_rsp_rdata", head ? m1_icb_rsp_rdata : m0_icb_rsp_rdata, sb[0].rdata);
            chk("sb_rsp_usr", head ? m1_icb_rsp_usr : m0_icb_rsp_usr, 1'b1);
            chk("sb_o_rsp_ready", o_icb_rsp_ready, eorr);
        end else begin
            chk("sb_no_rsp_valid", {m0_icb_rsp_valid, m1_icb_rsp_valid}, 2'b00);
        end
        if (rv_eff && eorr) begin
            popped = sb.pop_front();
            rsp_log.push_back(popped.id);
        end
        if (eov) begin
            sb.push_back('{id: gid, rdata: (gid ? 32'h0000_000B : 32'h0000_000A)});
            grant_log.push_back(gid);
            mdl_rr = ~gid;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        // m0a/m1a, scr, rv, rdata, m0rr, m1rr | e_ov e_m0r e_m1r e_addr e_rd e_m0rv e_m1rv e_orr e_act
        tbl[0]  = '{1'b0,1'b0,19'h0,  19'h0,  1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,1'b0,19'h0,  1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,19'h10, 19'h0,  1'b1,1'b0,32'h0,        1'b0,1'b0, 1'b1,1'b1,1'b0,19'h10, 1'b1,1'b0,1'b0,1'b0,1'b1};
        tbl[2]  = '{1'b0,1'b0,19'h0,  19'h0,  1'b0,1'b1,32'hDEADBEEF, 1'b1,1'b1, 1'b0,1'b0,1'b0,19'h0,  1'b0,1'b1,1'b0,1'b1,1'b1};
        tbl[3]  = '{1'b1,1'b1,19'h100,19'h200,1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b1,1'b0,1'b0,19'h200,1'b0,1'b0,1'b0,1'b0,1'b1};
        tbl[4]  = '{1'b1,1'b1,19'h100,19'h200,1'b1,1'b0,32'h0,        1'b0,1'b0, 1'b1,1'b0,1'b1,19'h200,1'b0,1'b0,1'b0,1'b0,1'b1};
        tbl[5]  = '{1'b1,1'b1,19'h100,19'h200,1'b1,1'b0,32'h0,        1'b0,1'b0, 1'b1,1'b1,1'b0,19'h100,1'b1,1'b0,1'b0,1'b0,1'b1};
        tbl[6]  = '{1'b1,1'b1,19'h100,19'h200,1'b1,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,1'b0,19'h0,  1'b0,1'b0,1'b0,1'b0,1'b1};
        tbl[7]  = '{1'b1,1'b1,19'h100,19'h200,1'b1,1'b1,32'h11111111, 1'b0,1'b1, 1'b0,1'b0,1'b0,19'h0,  1'b0,1'b0,1'b1,1'b1,1'b1};
        tbl[8]  = '{1'b1,1'b1,19'h100,19'h200,1'b1,1'b1,32'h22222222, 1'b0,1'b1, 1'b1,1'b0,1'b1,19'h200,1'b0,1'b1,1'b0,1'b0,1'b1};
        tbl[9]  = '{1'b0,1'b0,19'h0,  19'h0,  1'b0,1'b1,32'h33333333, 1'b1,1'b0, 1'b0,1'b0,1'b0,19'h0,  1'b0,1'b1,1'b0,1'b1,1'b1};
        tbl[10] = '{1'b0,1'b0,19'h0,  19'h0,  1'b0,1'b1,32'h44444444, 1'b1,1'b1, 1'b0,1'b0,1'b0,19'h0,  1'b0,1'b0,1'b1,1'b1,1'b1};
        tbl[11] = '{1'b0,1'b0,19'h0,  19'h0,  1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,1'b0,19'h0,  1'b0,1'b0,1'b0,1'b0,1'b0};

        do_reset();
        chk("rst_count", dut.w_fifo_count, 2'd0);
        chk("rst_rr_ptr", dut.r_rr_ptr, 1'b0);

        // Table: single read, stall without rotation, full FIFO, pop-cycle block.
        for (int i = 0; i < 12; i++) begin
            m0_icb_cmd_valid = tbl[i].m0v;  m1_icb_cmd_valid = tbl[i].m1v;
            m0_icb_cmd_addr  = tbl[i].m0a;  m1_icb_cmd_addr  = tbl[i].m1a;
            o_icb_cmd_ready  = tbl[i].scr;  o_icb_rsp_valid  = tbl[i].rv;
            o_icb_rsp_rdata  = tbl[i].rdata;
            m0_icb_rsp_ready = tbl[i].m0rr; m1_icb_rsp_ready = tbl[i].m1rr;
            #2;
            chk($sformatf("tbl%0d_cmd_valid", i), o_icb_cmd_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_m0_cmd_ready", i), m0_icb_cmd_ready, tbl[i].e_m0r);
            chk($sformatf("tbl%0d_m1_cmd_ready", i), m1_icb_cmd_ready, tbl[i].e_m1r);
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_cmd_addr", i), o_icb_cmd_addr, tbl[i].e_addr);
                chk($sformatf("tbl%0d_cmd_read", i), o_icb_cmd_read, tbl[i].e_rd);
            end
            chk($sformatf("tbl%0d_m0_rsp_valid", i), m0_icb_rsp_valid, tbl[i].e_m0rv);
            chk($sformatf("tbl%0d_m1_rsp_valid", i), m1_icb_rsp_valid, tbl[i].e_m1rv);
            chk($sformatf("tbl%0d_o_rsp_ready", i), o_icb_rsp_ready, tbl[i].e_orr);
            chk($sformatf("tbl%0d_arb_active", i), arb_active, tbl[i].e_act);
            if (tbl[i].e_m0rv) chk($sformatf("tbl%0d_m0_rdata", i), m0_icb_rsp_rdata, tbl[i].rdata);
            if (tbl[i].e_m1rv) chk($sformatf("tbl%0d_m1_rdata", i), m1_icb_rsp_rdata, tbl[i].rdata);
            @(posedge clk); #1;
        end

        // Both masters requesting for 4 handshakes, prompt responses.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            m0_icb_cmd_addr = 19'h100 + 19'(k);
            m1_icb_cmd_addr = 19'h200 + 19'(k);
            sb_cycle(k < 4, k < 4, 1'b1, 1'b1, 1'b1);
        end
        chk("rr_grant_cnt", grant_log.size(), 4);
        chk("rr_rsp_cnt", rsp_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < grant_log.size()) chk($sformatf("rr_grant%0d", k), grant_log[k], k % 2);
            if (k < rsp_log.size())   chk($sformatf("rr_rsp%0d", k), rsp_log[k], k % 2);
        end

        // M1 write, M1 holds rsp_ready low for 3 cycles.
        do_reset();
        m1_icb_cmd_read  = 1'b0;
        m1_icb_cmd_addr  = 19'h00400;
        m1_icb_cmd_wdata = 32'h1234ABCD;
        m1_icb_cmd_wmask = 4'b0011;
        sb_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("hold_count_push", dut.w_fifo_count, 2'd1);
        for (int k = 0; k < 3; k++) begin
            sb_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            chk($sformatf("hold_count%0d", k), dut.w_fifo_count, 2'd1);
        end
        sb_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("hold_count_pop", dut.w_fifo_count, 2'd0);

        // Interleaved reads; M1 raises rsp_ready before M0.
        do_reset();
        m0_icb_cmd_addr = 19'h00020;
        m1_icb_cmd_addr = 19'h00040;
        m1_icb_cmd_read = 1'b1;
        sb_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sb_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        sb_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        sb_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("ilv_rsp_cnt", rsp_log.size(), 2);
        if (rsp_log.size() == 2) begin
            chk("ilv_first_to_m0", rsp_log[0], 1'b0);
            chk("ilv_second_to_m1", rsp_log[1], 1'b1);
        end

        // Reset with two commands outstanding.
        do_reset();
        sb_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sb_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_pre_count", dut.w_fifo_count, 2'd2);
        chk("mid_pre_rr", dut.r_rr_ptr, 1'b1);
        idle_inputs();
        rst = 1'b1;
        o_icb_rsp_valid  = 1'b1;
        m0_icb_rsp_ready = 1'b1;
        m1_icb_rsp_ready = 1'b1;
        #2;
        chk("mid_count", dut.w_fifo_count, 2'd0);
        chk("mid_rr", dut.r_rr_ptr, 1'b0);
        chk("mid_rsp_valids", {m0_icb_rsp_valid, m1_icb_rsp_valid}, 2'b00);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;
        mdl_rr = 1'b0;
        sb.delete();
        sb_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_first_grant", (grant_log.size() > 0) ? grant_log[grant_log.size()-1] : 1'bx, 1'b0);
        sb_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("end_count", dut.w_fifo_count, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
